pio_cq_rx: RTL and testbench

- Completer-request receive stage for the PIO endpoint.
- Consumes the 64-bit CQ AXI-stream produced by the PCIe core, or by the host stimulus model in simulation.
- Parses the 128-bit CQ descriptor, which arrives over 2 beats.
- Issues single-dword register writes directly, and hands single-dword read requests to the downstream completion generator, which drives CC.
- Unsupported requests are drained and counted.

---
 rtl/pio_pkg.sv | 38 +++
 rtl/pio_cq_desc_decode.sv | 27 ++
 rtl/pio_cq_rx.sv | 179 +++++++++++++++++
 tb/tb_pio_cq_rx.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// pio_pkg: CQ descriptor types shared by the PIO receive path and CC bench.
// The 128-bit descriptor arrives as two 64-bit beats; offsets are per beat.
package pio_pkg;

  typedef enum logic [3:0] {
    MEM_RD = 4'h0,
    MEM_WR = 4'h1
  } req_type_e;

  localparam int B0_AT_LSB   = 0;
  localparam int B1_DWC_LSB  = 0;
  localparam int B1_TYPE_LSB = 11;
  localparam int B1_RID_LSB  = 16;
  localparam int B1_TAG_LSB  = 32;
  localparam int B1_TC_LSB   = 57;
  localparam int B1_ATTR_LSB = 60;

  typedef struct packed {
    logic [63:0] addr;
    logic [1:0]  at;
    logic [10:0] dword_count;
    req_type_e   req_type;
    logic [15:0] rid;
    logic [7:0]  tag;
    logic [2:0]  tc;
    logic [2:0]  attr;
    logic [3:0]  first_be;
  } cq_desc_t;

  typedef enum logic [2:0] {
    DESC0,
    DESC1,
    DATA,
    RD_WAIT,
    DISCARD
  } cq_state_e;

endpackage

// File: rtl/pio_cq_desc_decode.sv
// pio_cq_desc_decode: pure field extraction for CQ descriptor beats.
// beat0 carries only address/AT/first_be; beat1 carries the rest.
module pio_cq_desc_decode
  import pio_pkg::*;
(
  input  logic [63:0] tdata,
  input  logic [3:0]  first_be,
  output cq_desc_t    beat0,
  output cq_desc_t    beat1
);

  always_comb begin
    beat0          = '0;
    beat0.addr     = tdata & ~64'h3;
    beat0.at       = tdata[B0_AT_LSB +: 2];
    beat0.first_be = first_be;

    beat1             = '0;
    beat1.dword_count = tdata[B1_DWC_LSB +: 11];
    beat1.req_type    = req_type_e'(tdata[B1_TYPE_LSB +: 4]);
    beat1.rid         = tdata[B1_RID_LSB +: 16];
    beat1.tag         = tdata[B1_TAG_LSB +: 8];
    beat1.tc          = tdata[B1_TC_LSB +: 3];
    beat1.attr        = tdata[B1_ATTR_LSB +: 3];
  end

endmodule

// File: rtl/pio_cq_rx.sv
// pio_cq_rx: CQ receive stage; 1-DW writes issued, 1-DW reads handed off.
// Define PIO_DROP_CNT_EN to implement the saturating drop_count.
module pio_cq_rx
  import pio_pkg::*;
#(
  parameter int C_DATA_WIDTH = 64,
  parameter int KEEP_WIDTH   = C_DATA_WIDTH / 32,
  parameter int ADDR_WIDTH   = 12
) (
  input  logic                    user_clk,
  input  logic                    reset_n,
  input  logic [C_DATA_WIDTH-1:0] cq_tdata,
  input  logic [84:0]             cq_tuser,
  input  logic                    cq_tlast,
  input  logic [KEEP_WIDTH-1:0]   cq_tkeep,
  input  logic                    cq_tvalid,
  output logic                    cq_tready,
  output logic                    rd_req_valid,
  input  logic                    rd_req_ready,
  output logic [ADDR_WIDTH-1:0]   rd_req_addr,
  output logic [1:0]              rd_req_at,
  output logic [15:0]             rd_req_rid,
  output logic [7:0]              rd_req_tag,
  output logic [2:0]              rd_req_tc,
  output logic [2:0]              rd_req_attr,
  output logic [3:0]              rd_req_first_be,
  output logic                    wr_en,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [31:0]             wr_data,
  output logic [3:0]              wr_be,
  output logic [15:0]             drop_count
);

  cq_state_e state_q, state_d;
  cq_desc_t  desc_q, desc_d;
  cq_desc_t  d0, d1;
  logic      live_q;
  logic      wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [3:0]  wr_be_q, wr_be_d;
  logic acc, drop, rd_ok, wr_ok;

  pio_cq_desc_decode u_dec (
    .tdata    (cq_tdata),
    .first_be (cq_tuser[3:0]),
    .beat0    (d0),
    .beat1    (d1)
  );

  assign cq_tready = live_q && (state_q != RD_WAIT);
  assign acc       = cq_tvalid && cq_tready;

  assign rd_ok = (d1.req_type == MEM_RD) &&
                 (d1.dword_count == 11'd1) && cq_tlast;
  assign wr_ok = (d1.req_type == MEM_WR) &&
                 (d1.dword_count == 11'd1) && !cq_tlast;

  always_comb begin
    state_d   = state_q;
    desc_d    = desc_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_be_d   = wr_be_q;
    drop      = 1'b0;
    unique case (state_q)
      DESC0: begin
        if (acc) begin
          desc_d.addr     = d0.addr;
          desc_d.at       = d0.at;
          desc_d.first_be = d0.first_be;
          if (cq_tlast) drop = 1'b1;
          else          state_d = DESC1;
        end
      end
      DESC1: begin
        if (acc) begin
          desc_d.dword_count = d1.dword_count;
          desc_d.req_type    = d1.req_type;
          desc_d.rid         = d1.rid;
          desc_d.tag         = d1.tag;
          desc_d.tc          = d1.tc;
          desc_d.attr        = d1.attr;
          unique case (1'b1)
            rd_ok: state_d = RD_WAIT;
            wr_ok: state_d = DATA;
            default: begin
              drop    = 1'b1;
              state_d = cq_tlast ? DESC0 : DISCARD;
            end
          endcase
        end
      end
      DATA: begin
        if (acc) begin
          if (!cq_tlast) begin
            drop    = 1'b1;
            state_d = DISCARD;
          end else if (cq_tkeep[0]) begin
            wr_en_d   = 1'b1;
            wr_addr_d = desc_q.addr[ADDR_WIDTH-1:0];
            wr_data_d = cq_tdata[31:0];
            wr_be_d   = desc_q.first_be;
            state_d   = DESC0;
          end else begin
            drop    = 1'b1;
            state_d = DESC0;
          end
        end
      end
      RD_WAIT: begin
        if (rd_req_ready) state_d = DESC0;
      end
      DISCARD: begin
        if (acc && cq_tlast) state_d = DESC0;
      end
      default: state_d = DESC0;
    endcase
  end

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= DESC0;
      live_q    <= 1'b0;
      desc_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_be_q   <= '0;
    end else begin
      state_q   <= state_d;
      live_q    <= 1'b1;
      desc_q    <= desc_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_be_q   <= wr_be_d;
    end
  end

  // Valid is decoded from state so reset withdraws it asynchronously.
  assign rd_req_valid    = (state_q == RD_WAIT);
  assign rd_req_addr     = desc_q.addr[ADDR_WIDTH-1:0];
  assign rd_req_at       = desc_q.at;
  assign rd_req_rid      = desc_q.rid;
  assign rd_req_tag      = desc_q.tag;
  assign rd_req_tc       = desc_q.tc;
  assign rd_req_attr     = desc_q.attr;
  assign rd_req_first_be = desc_q.first_be;

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_be   = wr_be_q;

`ifdef PIO_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF))
      drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) drop_cnt_q <= '0;
    else          drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = '0;
`endif

  logic unused_ok;
  assign unused_ok = ^{d0, d1, desc_q, cq_tuser[84:4], cq_tkeep, drop};

endmodule

// File: tb/tb_pio_cq_rx.sv
// tb_pio_cq_rx: directed CQ TLPs with a queue-based scoreboard.
// A monitor pops expected writes/reads as the DUT presents them.
module tb_pio_cq_rx;

  logic        user_clk = 1'b0;
  logic        reset_n;
  logic [63:0] cq_tdata;
  logic [84:0] cq_tuser;
  logic        cq_tlast;
  logic [1:0]  cq_tkeep;
  logic        cq_tvalid;
  logic        cq_tready;
  logic        rd_req_valid;
  logic        rd_req_ready;
  logic [11:0] rd_req_addr;
  logic [1:0]  rd_req_at;
  logic [15:0] rd_req_rid;
  logic [7:0]  rd_req_tag;
  logic [2:0]  rd_req_tc;
  logic [2:0]  rd_req_attr;
  logic [3:0]  rd_req_first_be;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic [15:0] drop_count;

  int n_checks = 0;
  int n_errors = 0;
  int exp_drop = 0;
  logic [47:0] wr_q[$];
  logic [47:0] rd_q[$];

  always #5 user_clk = ~user_clk;

  pio_cq_rx dut (
    .user_clk        (user_clk),
    .reset_n         (reset_n),
    .cq_tdata        (cq_tdata),
    .cq_tuser        (cq_tuser),
    .cq_tlast        (cq_tlast),
    .cq_tkeep        (cq_tkeep),
    .cq_tvalid       (cq_tvalid),
    .cq_tready       (cq_tready),
    .rd_req_valid    (rd_req_valid),
    .rd_req_ready    (rd_req_ready),
    .rd_req_addr     (rd_req_addr),
    .rd_req_at       (rd_req_at),
    .rd_req_rid      (rd_req_rid),
    .rd_req_tag      (rd_req_tag),
    .rd_req_tc       (rd_req_tc),
    .rd_req_attr     (rd_req_attr),
    .rd_req_first_be (rd_req_first_be),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .wr_be           (wr_be),
    .drop_count      (drop_count)
  );

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  function automatic logic [47:0] rd_now();
    return {rd_req_addr, rd_req_at, rd_req_rid, rd_req_tag,
            rd_req_tc, rd_req_attr, rd_req_first_be};
  endfunction

  function automatic logic [47:0] rd_exp(
      input logic [11:0] a, input logic [1:0] at,
      input logic [15:0] rid, input logic [7:0] tag,
      input logic [2:0] tc, input logic [2:0] attr,
      input logic [3:0] be);
    return {a, at, rid, tag, tc, attr, be};
  endfunction

  function automatic logic [15:0] drop_exp();
`ifdef PIO_DROP_CNT_EN
    return 16'(exp_drop);
`else
    return 16'd0;
`endif
  endfunction

  task automatic beat(input logic [63:0] d, input logic [3:0] be,
                      input logic last, input logic [1:0] keep);
    int n = 0;
    cq_tdata  = d;
    cq_tuser  = {81'd0, be};
    cq_tlast  = last;
    cq_tkeep  = keep;
    cq_tvalid = 1'b1;
    while (!cq_tready && n < 50) begin
      @(negedge user_clk);
      n++;
    end
    if (!cq_tready) chk("beat_accept_timeout", cq_tready, 1);
    @(negedge user_clk);
    cq_tvalid = 1'b0;
  endtask

  task automatic rd_hold(input logic [47:0] exp, input int n);
    chk("rd_valid_rise", rd_req_valid, 1);
    for (int i = 0; i < n; i++) begin
      chk("rd_tready_low", cq_tready, 0);
      chk("rd_fields_hold", rd_now(), exp);
      @(negedge user_clk);
    end
    rd_req_ready = 1'b1;
    @(negedge user_clk);
    rd_req_ready = 1'b0;
    chk("rd_valid_drop", rd_req_valid, 0);
    chk("rd_tready_back", cq_tready, 1);
  endtask

  // Monitor: one sample per cycle, after inputs settle before the edge.
  initial begin
    logic [47:0] e;
    forever begin
      @(negedge user_clk);
      #1;
      if (wr_en) begin
        if (wr_q.size() == 0) begin
          chk("wr_spurious", {63'd0, wr_en}, 0);
        end else begin
          e = wr_q.pop_front();
          chk("wr_fields", {wr_addr, wr_data, wr_be}, e);
        end
      end
      if (rd_req_valid && rd_req_ready) begin
        if (rd_q.size() == 0) begin
          chk("rd_spurious", {63'd0, rd_req_valid}, 0);
        end else begin
          e = rd_q.pop_front();
          chk("rd_fields", rd_now(), e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] r;
    reset_n      = 1'b0;
    cq_tdata     = '0;
    cq_tuser     = '0;
    cq_tlast     = 1'b0;
    cq_tkeep     = '0;
    cq_tvalid    = 1'b0;
    rd_req_ready = 1'b0;
    repeat (3) @(negedge user_clk);
    chk("rst_tready", cq_tready, 0);
    chk("rst_rd_valid", rd_req_valid, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_rd_fields", rd_now(), 0);
    chk("rst_wr_fields", {wr_addr, wr_data, wr_be}, 0);
    reset_n = 1'b1;
    @(negedge user_clk);
    chk("post_rst_tready", cq_tready, 1);

    // Basic read held off for three cycles
    r = rd_exp(12'h000, 2'd0, 16'h7000, 8'h00, 3'd0, 3'd0, 4'hF);
    rd_q.push_back(r);
    beat(64'h00000000_c0004000, 4'hF, 1'b0, 2'b11);
    beat(64'h00000000_70000001, 4'h0, 1'b1, 2'b11);
    rd_hold(r, 3);

    // Single-dword write
    wr_q.push_back({12'h010, 32'hdeadbeef, 4'hF});
    beat(64'h00000000_00000010, 4'hF, 1'b0, 2'b11);
    beat(64'h00000000_70000801, 4'h0, 1'b0, 2'b11);
    beat(64'h00000000_deadbeef, 4'h0, 1'b1, 2'b01);

    // Unsupported request type, three beats
    beat(64'h00000000_00000020, 4'hF, 1'b0, 2'b11);
    beat(64'h00000000_70001001, 4'h0, 1'b0, 2'b11);
    beat(64'h00000000_11111111, 4'h0, 1'b1, 2'b11);
    exp_drop++;
    chk("drop_unsupported", drop_count, drop_exp());

    // Two-dword write dropped, then a write right behind it
    wr_q.push_back({12'h7FC, 32'h0badf00d, 4'h6});
    beat(64'h00000000_00000030, 4'hF, 1'b0, 2'b11);
    beat(64'h00000000_70000802, 4'h0, 1'b0, 2'b11);
    beat(64'h00000000_12341234, 4'h0, 1'b1, 2'b11);
    exp_drop++;
    beat(64'h00000000_000007FC, 4'h6, 1'b0, 2'b11);
    beat(64'h00000000_70000801, 4'h0, 1'b0, 2'b11);
    beat(64'h00000000_0badf00d, 4'h0, 1'b1, 2'b01);
    chk("drop_multi_dw", drop_count, drop_exp());

    // Back-to-back write then read with non-trivial fields
    wr_q.push_back({12'hABC, 32'h12345678, 4'h1});
    r = rd_exp(12'h344, 2'd2, 16'h1234, 8'hA5, 3'd5, 3'd3, 4'h3);
    rd_q.push_back(r);
    beat(64'h00000001_00000ABC, 4'h1, 1'b0, 2'b11);
    beat(64'h00000000_70000801, 4'h0, 1'b0, 2'b11);
    beat(64'h00000000_12345678, 4'h0, 1'b1, 2'b01);
    beat(64'h00000000_00000346, 4'h3, 1'b0, 2'b11);
    beat(64'h3A0000A5_12340001, 4'h0, 1'b1, 2'b11);
    rd_hold(r, 1);

    // Drop corners: 1-beat TLP, write with tkeep[0]=0, read too long
    beat(64'h00000000_00000040, 4'hF, 1'b1, 2'b11);
    exp_drop++;
    beat(64'h00000000_00000044, 4'hF, 1'b0, 2'b11);
    beat(64'h00000000_70000801, 4'h0, 1'b0, 2'b11);
    beat(64'h00000000_55555555, 4'h0, 1'b1, 2'b10);
    exp_drop++;
    beat(64'h00000000_00000048, 4'hF, 1'b0, 2'b11);
    beat(64'h00000000_70000001, 4'h0, 1'b0, 2'b11);
    beat(64'h00000000_66666666, 4'h0, 1'b1, 2'b11);
    exp_drop++;
    chk("drop_corners", drop_count, drop_exp());

    // Reset while a read is pending
    beat(64'h00000000_00000100, 4'hF, 1'b0, 2'b11);
    beat(64'h00000000_70000001, 4'h0, 1'b1, 2'b11);
    chk("rst_mid_valid_before", rd_req_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_valid_async", rd_req_valid, 0);
    chk("rst_mid_tready", cq_tready, 0);
    exp_drop = 0;
    @(negedge user_clk);
    chk("rst_mid_drop", drop_count, drop_exp());
    reset_n = 1'b1;
    @(negedge user_clk);
    chk("rst_mid_tready_back", cq_tready, 1);

    r = rd_exp(12'h204, 2'd0, 16'hBEEF, 8'h11, 3'd0, 3'd0, 4'hC);
    rd_q.push_back(r);
    beat(64'h00000000_00000204, 4'hC, 1'b0, 2'b11);
    beat(64'h00000011_BEEF0001, 4'h0, 1'b1, 2'b11);
    rd_hold(r, 2);

    repeat (3) @(negedge user_clk);
    chk("wr_queue_empty", 64'(wr_q.size()), 0);
    chk("rd_queue_empty", 64'(rd_q.size()), 0);
    chk("drop_final", drop_count, drop_exp());

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
